// File: rtl/mips_pkg.sv
// Shared MIPS definitions: HI/LO unit operation encodings and its sequencer states.
package mips_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring divide on the {acc_hi, acc_lo} pair.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // Divide: the partial remainder stays below the divisor, so a WIDTH-bit difference is exact
    // whenever the trial subtraction succeeds.
    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        diff    = shifted[WIDTH-1:0] - operand;
        next_hi = sum[WIDTH:1];
        next_lo = {sum[0], acc_lo[WIDTH-1:1]};
        if (is_div) begin
            if (shifted >= {1'b0, operand}) begin
                next_hi = diff;
                next_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                next_hi = shifted[WIDTH-1:0];
                next_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers; WIDTH run cycles plus a sign-fix cycle.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t             state;
    state_t             next_state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_fix;

    assign signed_op   = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg       = signed_op & a[WIDTH-1];
    assign b_neg       = signed_op & b[WIDTH-1];
    assign a_mag       = a_neg ? -a : a;
    assign b_mag       = b_neg ? -b : b;
    assign product     = {acc_hi, acc_lo};
    assign product_fix = neg_q ? -product : product;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .operand (operand),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start) next_state = ST_RUN;
            ST_RUN:  if (cnt == CW'(WIDTH - 1)) next_state = ST_FIX;
            ST_FIX:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // A zero divisor leaves the quotient unsigned (all ones) and the remainder equal to the dividend.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            operand <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
        end else begin
            busy <= (next_state != ST_IDLE);
            done <= (state == ST_FIX);
            case (state)
                ST_IDLE: begin
                    if (we_hi) hi <= wd;
                    if (we_lo) lo <= wd;
                    if (start) begin
                        cnt     <= '0;
                        is_div  <= op[1];
                        neg_q   <= (a_neg ^ b_neg) & (b != '0);
                        neg_r   <= a_neg;
                        operand <= b_mag;
                        acc_hi  <= '0;
                        acc_lo  <= a_mag;
                    end
                end
                ST_RUN: begin
                    cnt    <= cnt + 1'b1;
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                end
                ST_FIX: begin
                    if (is_div) begin
                        lo <= neg_q ? -acc_lo : acc_lo;
                        hi <= neg_r ? -acc_hi : acc_hi;
                    end else begin
                        hi <= product_fix[2*WIDTH-1:WIDTH];
                        lo <= product_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32: latency, signed/unsigned results, busy lockout, reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        we_hi;
    logic        we_lo;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .we_hi (we_hi),
        .we_lo (we_lo),
        .wd    (wd),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Called 1 time unit after a rising edge; returns 1 time unit after the start edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int edges, output bit timed_out);
        edges     = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd3;
        b     = 32'd4;
        we_hi = 1'b1;
        we_lo = 1'b1;
        wd    = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo got %h want 0", lo); end
        start = 1'b0;
        we_hi = 1'b0;
        we_lo = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset_busy got %b want 0", busy); end
    endtask

    task automatic test_multu_max();
        int done_edge   = -1;
        int busy_cycles = 0;
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        if (busy) busy_cycles++;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cycles++;
            if (done && done_edge < 0) begin
                done_edge = i;
                break;
            end
        end
        checks++; if (done_edge !== 33) begin errors++; $display("[TB] FAIL multu_done_edge got %0d want 33", done_edge); end
        checks++; if (busy_cycles !== 33) begin errors++; $display("[TB] FAIL multu_busy_cycles got %0d want 33", busy_cycles); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL multu_busy_in_done got %b want 0", busy); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL multu_max_hi got %h want fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("[TB] FAIL multu_max_lo got %h want 00000001", lo); end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL multu_done_pulse got %b want 0", done); end
    endtask

    task automatic test_mult_signed();
        int edges;
        bit to;
        issue(2'b00, 32'hFFFF_FFFD, 32'd7);
        wait_done(edges, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL mult_timeout got timeout want done"); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mult_neg_hi got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("[TB] FAIL mult_neg_lo got %h want ffffffeb", lo); end
        issue(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFB);
        wait_done(edges, to);
        checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL mult_negneg_hi got %h want 0", hi); end
        checks++; if (lo !== 32'd10) begin errors++; $display("[TB] FAIL mult_negneg_lo got %h want 0000000a", lo); end
    endtask

    task automatic test_div_signed();
        int edges;
        bit to;
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(edges, to);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL div_m7_2_lo got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL div_m7_2_hi got %h want ffffffff", hi); end
        issue(2'b10, 32'd7, 32'hFFFF_FFFE);
        wait_done(edges, to);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL div_7_m2_lo got %h want fffffffd", lo); end
        checks++; if (hi !== 32'd1) begin errors++; $display("[TB] FAIL div_7_m2_hi got %h want 00000001", hi); end
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(edges, to);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("[TB] FAIL div_ovf_lo got %h want 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL div_ovf_hi got %h want 0", hi); end
    endtask

    task automatic test_div_zero();
        int edges;
        bit to;
        issue(2'b11, 32'd100, 32'd0);
        wait_done(edges, to);
        checks++; if (edges !== 33) begin errors++; $display("[TB] FAIL divu_zero_latency got %0d want 33", edges); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL divu_zero_lo got %h want ffffffff", lo); end
        checks++; if (hi !== 32'd100) begin errors++; $display("[TB] FAIL divu_zero_hi got %h want 00000064", hi); end
        issue(2'b10, 32'hFFFF_FFFB, 32'd0);
        wait_done(edges, to);
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL div_zero_lo got %h want ffffffff", lo); end
        checks++; if (hi !== 32'hFFFF_FFFB) begin errors++; $display("[TB] FAIL div_zero_hi got %h want fffffffb", hi); end
    endtask

    task automatic test_busy_ignore();
        int edges;
        bit to;
        issue(2'b01, 32'd6, 32'd7);
        for (int i = 1; i <= 4; i++) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'b11;
        a     = 32'd9;
        b     = 32'd3;
        we_hi = 1'b1;
        wd    = 32'h55;
        @(posedge clk);
        #1;
        start = 1'b0;
        we_hi = 1'b0;
        checks++; if (hi === 32'h55) begin errors++; $display("[TB] FAIL ignore_we_hi got %h want not 00000055", hi); end
        wait_done(edges, to);
        checks++; if (edges !== 28) begin errors++; $display("[TB] FAIL ignore_latency got %0d want 28", edges); end
        checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL ignore_hi got %h want 0", hi); end
        checks++; if (lo !== 32'd42) begin errors++; $display("[TB] FAIL ignore_lo got %h want 0000002a", lo); end
    endtask

    task automatic test_back_to_back();
        int edges;
        bit to;
        issue(2'b01, 32'd5, 32'd5);
        wait_done(edges, to);
        checks++; if (lo !== 32'd25) begin errors++; $display("[TB] FAIL b2b_first_lo got %h want 00000019", lo); end
        issue(2'b11, 32'd100, 32'd7);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy got %b want 1", busy); end
        wait_done(edges, to);
        checks++; if (edges !== 33) begin errors++; $display("[TB] FAIL b2b_latency got %0d want 33", edges); end
        checks++; if (lo !== 32'd14) begin errors++; $display("[TB] FAIL b2b_lo got %h want 0000000e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("[TB] FAIL b2b_hi got %h want 00000002", hi); end
    endtask

    task automatic test_write_start();
        int edges;
        bit to;
        we_lo = 1'b1;
        wd    = 32'h77;
        @(posedge clk);
        #1;
        we_lo = 1'b0;
        checks++; if (lo !== 32'h77) begin errors++; $display("[TB] FAIL idle_we_lo got %h want 00000077", lo); end
        we_hi = 1'b1;
        wd    = 32'hABCD;
        issue(2'b01, 32'd2, 32'd3);
        we_hi = 1'b0;
        checks++; if (hi !== 32'hABCD) begin errors++; $display("[TB] FAIL start_we_hi got %h want 0000abcd", hi); end
        wait_done(edges, to);
        checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL start_we_result_hi got %h want 0", hi); end
        checks++; if (lo !== 32'd6) begin errors++; $display("[TB] FAIL start_we_result_lo got %h want 00000006", lo); end
    endtask

    task automatic test_reset_mid_run();
        issue(2'b01, 32'd6, 32'd7);
        for (int i = 1; i <= 10; i++) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrun_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midrun_done got %b want 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL midrun_hi got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("[TB] FAIL midrun_lo got %h want 0", lo); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        we_lo = 1'b1;
        wd    = 32'h1234;
        @(posedge clk);
        #1;
        we_lo = 1'b0;
        checks++; if (lo !== 32'h1234) begin errors++; $display("[TB] FAIL post_reset_we_lo got %h want 00001234", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_div_signed();
        test_div_zero();
        test_busy_ignore();
        test_back_to_back();
        test_write_start();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
